// File: rtl/mem_port_arbiter_pkg.sv
// pika_mem_pkg: shared state encoding, owner codes and error data for the memory port arbiter.
package pika_mem_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA = 1'b1;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory handshake bundle for the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic f_req;
  logic [ADDR_W-1:0] f_addr;
  logic f_ack;
  logic f_err;
  logic [DATA_W-1:0] f_rdata;
  logic d_req;
  logic d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic d_ack;
  logic d_err;
  logic [DATA_W-1:0] d_rdata;
  logic m_req;
  logic m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic m_ready;
  logic [DATA_W-1:0] m_rdata;
  logic busy;
  logic owner;
  modport slave (
    input f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
    output f_ack, f_err, f_rdata, d_ack, d_err, d_rdata, m_req, m_we, m_addr, m_wdata, busy, owner
  );
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
    input f_ack, f_err, f_rdata, d_ack, d_err, d_rdata, m_req, m_we, m_addr, m_wdata, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; on contention the requester not granted last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_idx,
  output logic gnt_vld
);
  always_comb begin
    gnt_vld = req0 | req1;
    gnt_idx = (req0 & req1) ? ~last : req1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data requesters
// with round-robin grant and a watchdog that turns a hung access into an error response.
module mem_port_arbiter
  import pika_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic last;
  logic [CW-1:0] cnt;
  logic gnt_idx, gnt_vld, timed_out, done;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] rd_data;
  rr_arb2 u_arb (
    .req0(bus.f_req),
    .req1(bus.d_req),
    .last(last),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld)
  );
  always_comb begin
    gnt_addr = gnt_idx ? bus.d_addr : bus.f_addr;
    timed_out = !bus.m_ready && cnt == CW'(TIMEOUT - 1);
    done = bus.m_ready || timed_out;
    rd_data = timed_out ? ERR_DATA : bus.m_rdata;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      last <= OWN_FETCH;
      cnt <= '0;
      bus.f_ack <= 1'b0;
      bus.f_err <= 1'b0;
      bus.f_rdata <= '0;
      bus.d_ack <= 1'b0;
      bus.d_err <= 1'b0;
      bus.d_rdata <= '0;
      bus.m_req <= 1'b0;
      bus.m_we <= 1'b0;
      bus.m_addr <= '0;
      bus.m_wdata <= '0;
      bus.busy <= 1'b0;
      bus.owner <= OWN_FETCH;
    end else begin
      bus.f_ack <= 1'b0;
      bus.f_err <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.d_err <= 1'b0;
      case (state)
        ST_IDLE: if (gnt_vld) begin
          state <= ST_BUSY;
          bus.owner <= gnt_idx;
          bus.m_req <= 1'b1;
          bus.busy <= 1'b1;
          bus.m_we <= gnt_idx & bus.d_we;
          bus.m_addr <= gnt_addr;
          bus.m_wdata <= gnt_idx ? bus.d_wdata : '0;
          cnt <= '0;
        end
        ST_BUSY: if (done) begin
          state <= ST_RESP;
          bus.m_req <= 1'b0;
          if (bus.owner == OWN_DATA) begin
            bus.d_ack <= 1'b1;
            bus.d_err <= timed_out;
            if (!bus.m_we) bus.d_rdata <= rd_data;
          end else begin
            bus.f_ack <= 1'b1;
            bus.f_err <= timed_out;
            bus.f_rdata <= rd_data;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        ST_RESP: begin
          state <= ST_IDLE;
          bus.busy <= 1'b0;
          last <= bus.owner;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  a_one_ack: assert property (@(posedge clk) disable iff (!reset) !(bus.f_ack && bus.d_ack));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for the memory port arbiter.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int cnt;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.m_ready = 0; bus.m_rdata = '0;
    tick(); tick();
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_f_rdata", bus.f_rdata, 0);
    rst_n = 1;
    // lone fetch, m_ready already high in IDLE must be ignored
    bus.f_req = 1; bus.f_addr = 32'h100; bus.m_ready = 1; bus.m_rdata = 32'h12345678;
    tick();
    chk("lf_m_req", bus.m_req, 1);
    chk("lf_m_addr", bus.m_addr, 32'h100);
    chk("lf_m_we", bus.m_we, 0);
    chk("lf_early_ack", bus.f_ack, 0);
    tick();
    chk("lf_f_ack", bus.f_ack, 1);
    chk("lf_f_rdata", bus.f_rdata, 32'h12345678);
    chk("lf_f_err", bus.f_err, 0);
    chk("lf_d_ack", bus.d_ack, 0);
    chk("lf_resp_m_req", bus.m_req, 0);
    chk("lf_resp_busy", bus.busy, 1);
    bus.f_req = 0;
    tick();
    chk("lf_idle_busy", bus.busy, 0);
    chk("lf_ack_pulse", bus.f_ack, 0);
    // contention: data favoured, store
    bus.f_req = 1; bus.f_addr = 32'h104;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'hA5A5A5A5;
    bus.m_rdata = 32'h77777777;
    tick();
    chk("ct_owner_d", bus.owner, 1);
    chk("ct_m_we", bus.m_we, 1);
    chk("ct_m_addr", bus.m_addr, 32'h40);
    chk("ct_m_wdata", bus.m_wdata, 32'hA5A5A5A5);
    tick();
    chk("ct_d_ack", bus.d_ack, 1);
    chk("ct_f_ack0", bus.f_ack, 0);
    chk("ct_d_err", bus.d_err, 0);
    chk("ct_store_rdata", bus.d_rdata, 0);
    bus.d_req = 0; bus.d_we = 0;
    tick();
    bus.m_rdata = 32'h0BADF00D;
    tick();
    chk("ct_owner_f", bus.owner, 0);
    chk("ct_f_m_addr", bus.m_addr, 32'h104);
    chk("ct_f_m_wdata", bus.m_wdata, 0);
    tick();
    chk("ct_f_ack", bus.f_ack, 1);
    chk("ct_f_rdata", bus.f_rdata, 32'h0BADF00D);
    bus.f_req = 0;
    tick();
    // sustained contention: d,f,d,f,d,f
    bus.f_req = 1; bus.d_req = 1; bus.d_addr = 32'h80;
    for (int i = 0; i < 6; i++) begin
      bus.m_rdata = 32'h1000 + i;
      tick();
      chk($sformatf("ss_owner%0d", i), bus.owner, (i % 2 == 0) ? 1 : 0);
      tick();
      chk($sformatf("ss_dack%0d", i), bus.d_ack, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("ss_fack%0d", i), bus.f_ack, (i % 2 == 0) ? 0 : 1);
      chk($sformatf("ss_rdata%0d", i), (i % 2 == 0) ? bus.d_rdata : bus.f_rdata, 32'h1000 + i);
      tick();
      chk($sformatf("ss_idle%0d", i), bus.busy, 0);
    end
    bus.f_req = 0; bus.d_req = 0; bus.m_ready = 0;
    tick();
    // timeout on a load
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    tick();
    cnt = 0;
    for (int i = 0; i < 20 && bus.m_req; i++) begin
      cnt++;
      tick();
    end
    chk("to_m_req_cycles", cnt, 8);
    chk("to_d_ack", bus.d_ack, 1);
    chk("to_d_err", bus.d_err, 1);
    chk("to_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    bus.d_req = 0;
    tick();
    tick();
    // input change after grant, m_ready on the timeout edge
    bus.d_req = 1; bus.d_addr = 32'h40;
    tick();
    chk("ic_m_addr0", bus.m_addr, 32'h40);
    bus.d_addr = 32'h80;
    for (int i = 0; i < 7; i++) tick();
    chk("ic_m_addr", bus.m_addr, 32'h40);
    chk("ic_still_busy", bus.m_req, 1);
    bus.m_ready = 1; bus.m_rdata = 32'hCAFE0001;
    tick();
    chk("ic_d_ack", bus.d_ack, 1);
    chk("ic_d_err", bus.d_err, 0);
    chk("ic_d_rdata", bus.d_rdata, 32'hCAFE0001);
    bus.d_req = 0; bus.m_ready = 0;
    tick();
    tick();
    // asynchronous reset mid-BUSY
    bus.f_req = 1; bus.f_addr = 32'h200;
    tick();
    chk("rb_m_req", bus.m_req, 1);
    #2 rst_n = 0;
    #1;
    chk("rb_m_req0", bus.m_req, 0);
    chk("rb_busy0", bus.busy, 0);
    chk("rb_f_rdata0", bus.f_rdata, 0);
    chk("rb_d_rdata0", bus.d_rdata, 0);
    chk("rb_m_addr0", bus.m_addr, 0);
    tick();
    rst_n = 1; bus.m_ready = 1; bus.m_rdata = 32'h55AA55AA;
    tick();
    chk("rb_regrant", bus.m_addr, 32'h200);
    tick();
    chk("rb_f_ack", bus.f_ack, 1);
    chk("rb_f_rdata", bus.f_rdata, 32'h55AA55AA);
    bus.f_req = 0; bus.m_ready = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
